mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath (single memory, IR, A/B/ALUOut registers, one ALU) through fetch, decode, execute, memory and writeback steps, with a ready/wait handshake to instruction/data memory. It replaces the single-cycle decode path in the multicycle build and drives every datapath mux select and write enable.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  request is a write (valid only with mem_req)
- iord  out  1  address mux: 0 PC, 1 ALUOut
- irwrite  out  1  load IR
- regdst  out  1  0 rt, 1 rd
- memtoreg  out  1  0 ALUOut, 1 Data register
- regwrite  out  1  register file write
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  2  00 B, 01 constant 4, 10 extended imm, 11 sign imm << 2
- extop  out  1  0 sign-extend, 1 zero-extend
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pcen  out  1  PC write enable
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IMMEX, IMMWB, JEX.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00; irwrite and pcen asserted only when mem_ready; stay in FETCH until mem_ready, then DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). op 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000101 -> BNEEX; 001000/001100/001101/001010 -> IMMEX; 000010 -> JEX; any other -> FETCH with illegal_op=1.
- MEMADR: alusrca=1, alusrcb=10, extop=0, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1; hold until mem_ready, then MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1; hold until mem_ready; instr_done on the mem_ready cycle -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00; alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other -> add. RTYPEWB: regdst=1, memtoreg=0, regwrite=1, instr_done.
- BEQEX / BNEEX: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen=zero (BEQ) or ~zero (BNE); instr_done -> FETCH.
- IMMEX: alusrca=1, alusrcb=10; addi add/extop 0, andi and/extop 1, ori or/extop 1, slti slt/extop 0. IMMWB: regdst=0, memtoreg=0, regwrite=1, instr_done.
- JEX: pcsrc=10, pcen=1, instr_done -> FETCH.
- Every output not listed for a state is 0 (alucontrol defaults to add).

## Timing
- State register updates on posedge clk; outputs combinational from state, plus op/funct/zero/mem_ready where listed (no registered outputs).
- Reset: state <= FETCH; while reset is high, mem_req, memwrite, irwrite, regwrite, pcen, instr_done, illegal_op forced 0; selects take FETCH values.
- Zero-wait memory cycle counts: lw 5, sw 4, R-type 4, I-type ALU 4, beq/bne 3, j 3, illegal 2.
- Each wait cycle (mem_ready=0) in FETCH/MEMRD/MEMWR adds exactly one cycle; no write enable other than mem_req/memwrite/iord asserts while waiting.
- mem_ready outside request states is ignored.
- Reset mid-instruction abandons it; next cycle after deassertion is FETCH with no partial writes.

## Structure
- Package mc_pkg: state enum, opcode and funct localparams, alucontrol, alusrcb, and pcsrc encodings.
- Sub-module mc_aludec: combinational funct -> alucontrol for RTYPEEX; FSM handles all other ALU ops.

## Test plan
- Reset held 3 cycles mid-MEMRD -> state FETCH, all enables 0 during reset; first post-reset cycle asserts mem_req with iord=0.
- lw (op 100011), mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 only in cycle 5; instr_done pulses once.
- sw with mem_ready low for 2 cycles in MEMWR -> memwrite held 3 cycles; instr_done only on ready cycle; total 6 cycles.
- beq zero=1 -> pcen=1, pcsrc=01 in cycle 3; bne zero=1 -> pcen=0; bne zero=0 -> pcen=1.
- R-type funct 101010 -> alucontrol 111 in RTYPEEX, regdst=1 in RTYPEWB; ori -> alucontrol 001, extop=1.
- op 111111 -> illegal_op pulses in DECODE, next state FETCH, no regwrite/memwrite/pcen.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes and the datapath select encodings driven by the controller.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BEQEX,
        BNEEX,
        IMMEX,
        IMMWB,
        JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle. Memory handshake: mem_req is held for
// as long as the access is pending; the access completes in the cycle mem_ready=1.
interface mc_controller_if;
    import mc_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       instr_done;
    logic       illegal_op;
    state_t     state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, extop, alucontrol, pcsrc, pcen,
               instr_done, illegal_op, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, extop, alucontrol, pcsrc, pcen,
               instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_aludec.sv
// R-type ALU decoder: maps funct to an alucontrol code; unknown functs add.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = ALU_ADD;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: alucontrol = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath, with
// outputs decoded combinationally from the state register.
module mc_controller
    import mc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    state_t     state;
    logic [2:0] rtype_alu;

    mc_aludec u_aludec (
        .funct      (bus.funct),
        .alucontrol (rtype_alu)
    );

    assign bus.state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW:                     state <= MEMADR;
                        OP_RTYPE:                         state <= RTYPEEX;
                        OP_BEQ:                           state <= BEQEX;
                        OP_BNE:                           state <= BNEEX;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= IMMEX;
                        OP_J:                             state <= JEX;
                        default:                          state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (bus.mem_ready) state <= MEMWB;
                MEMWR:   if (bus.mem_ready) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                IMMEX:   state <= IMMWB;
                default: state <= FETCH;
            endcase
        end
    end

    // During reset the state may still be stale, so outputs are forced to the
    // FETCH selects with every enable low.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = SRCB_B;
        bus.extop      = 1'b0;
        bus.alucontrol = ALU_ADD;
        bus.pcsrc      = PC_ALU;
        bus.pcen       = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        if (reset) begin
            bus.alusrcb = SRCB_FOUR;
        end else begin
            case (state)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.alusrcb = SRCB_FOUR;
                    bus.irwrite = bus.mem_ready;
                    bus.pcen    = bus.mem_ready;
                end
                DECODE: begin
                    bus.alusrcb = SRCB_BRANCH;
                    case (bus.op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI,
                        OP_ANDI, OP_ORI, OP_SLTI, OP_J: bus.illegal_op = 1'b0;
                        default:                        bus.illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_IMM;
                end
                MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                MEMWB: begin
                    bus.memtoreg   = 1'b1;
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEMWR: begin
                    bus.mem_req    = 1'b1;
                    bus.memwrite   = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                RTYPEEX: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = rtype_alu;
                end
                RTYPEWB: begin
                    bus.regdst     = 1'b1;
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BEQEX, BNEEX: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = ALU_SUB;
                    bus.pcsrc      = PC_ALUOUT;
                    bus.pcen       = (state == BEQEX) ? bus.zero : ~bus.zero;
                    bus.instr_done = 1'b1;
                end
                IMMEX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_IMM;
                    case (bus.op)
                        OP_ANDI: begin bus.alucontrol = ALU_AND; bus.extop = 1'b1; end
                        OP_ORI:  begin bus.alucontrol = ALU_OR;  bus.extop = 1'b1; end
                        OP_SLTI: bus.alucontrol = ALU_SLT;
                        default: bus.alucontrol = ALU_ADD;
                    endcase
                end
                IMMWB: begin
                    bus.regwrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                JEX: begin
                    bus.pcsrc      = PC_JUMP;
                    bus.pcen       = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: bus.alusrcb = SRCB_FOUR;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: each instruction is expanded into its per-cycle
// control trace, queued, and compared cycle by cycle by an independent monitor.
module tb_mc_controller;
    localparam int W = 19;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    ctl_t mon_exp;
    ctl_t mon_act;

    logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                             6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010,
                             6'b111111};
    logic [5:0] fns [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b000111};

    // ---------------- reference model ----------------
    function automatic ctl_t idle_vec();
        ctl_t c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic ctl_t fetch_vec();
        ctl_t c = idle_vec();
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        return c;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                          6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fetch_vec() & ~ctl_t'({1'b1, 18'b0}));
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        compared++;
        if (bus.state !== mc_pkg::FETCH) begin
            mismatched++;
            $display("FAIL reset_state: got %0d expected FETCH", bus.state);
        end
    endtask

    // fw/mw: wait cycles in fetch / data access; cut>0 stops after that many cycles
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int cut);
        ctl_t e[$];
        bit   r[$];
        ctl_t c;
        int   n;
        bus.op = op; bus.funct = fn; bus.zero = z;
        for (int i = 0; i < fw; i++) begin e.push_back(fetch_vec()); r.push_back(1'b0); end
        c = fetch_vec(); c.irwrite = 1'b1; c.pcen = 1'b1;
        e.push_back(c); r.push_back(1'b1);
        c = idle_vec(); c.alusrcb = 2'b11; c.illegal_op = !legal(op);
        e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
        case (op)
            6'b100011, 6'b101011: begin
                c = idle_vec(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
                c = idle_vec(); c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = (op == 6'b101011);
                for (int i = 0; i < mw; i++) begin e.push_back(c); r.push_back(1'b0); end
                if (op == 6'b101011) c.instr_done = 1'b1;
                e.push_back(c); r.push_back(1'b1);
                if (op == 6'b100011) begin
                    c = idle_vec(); c.memtoreg = 1'b1; c.regwrite = 1'b1; c.instr_done = 1'b1;
                    e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
                end
            end
            6'b000000: begin
                c = idle_vec(); c.alusrca = 1'b1; c.alucontrol = rtype_alu(fn);
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
                c = idle_vec(); c.regdst = 1'b1; c.regwrite = 1'b1; c.instr_done = 1'b1;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
            end
            6'b000100, 6'b000101: begin
                c = idle_vec(); c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
                c.pcen = (op == 6'b000100) ? z : !z; c.instr_done = 1'b1;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                c = idle_vec(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
                if (op == 6'b001100) begin c.alucontrol = 3'b000; c.extop = 1'b1; end
                if (op == 6'b001101) begin c.alucontrol = 3'b001; c.extop = 1'b1; end
                if (op == 6'b001010) c.alucontrol = 3'b111;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
                c = idle_vec(); c.regwrite = 1'b1; c.instr_done = 1'b1;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
            end
            6'b000010: begin
                c = idle_vec(); c.pcsrc = 2'b10; c.pcen = 1'b1; c.instr_done = 1'b1;
                e.push_back(c); r.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        n = (cut > 0 && cut < e.size()) ? cut : e.size();
        for (int i = 0; i < n; i++) exp_q.push_back(e[i]);
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = r[i];
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.regdst,
                       bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.extop,
                       bus.alucontrol, bus.pcsrc, bus.pcen, bus.instr_done, bus.illegal_op};
            compared++;
            if (mon_act !== mon_exp) begin
                mismatched++;
                $display("FAIL ctl cycle %0d op=%b funct=%b: got %b expected %b",
                         cyc, bus.op, bus.funct, mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         cut;
        reset = 1'b1;
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(6'b100011, 6'b0, 1'b0, 0, 0, 0);        // lw, 5 cycles
        run_instr(6'b100011, 6'b0, 1'b0, 0, 3, 4);        // lw abandoned in MEMRD
        do_reset(3);
        run_instr(6'b101011, 6'b0, 1'b0, 0, 2, 0);        // sw, 2 waits -> 6 cycles
        run_instr(6'b000100, 6'b0, 1'b1, 0, 0, 0);        // beq taken
        run_instr(6'b000101, 6'b0, 1'b1, 0, 0, 0);        // bne not taken
        run_instr(6'b000101, 6'b0, 1'b0, 1, 0, 0);        // bne taken, fetch wait
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 0);   // slt
        run_instr(6'b001101, 6'b0, 1'b0, 0, 0, 0);        // ori
        run_instr(6'b111111, 6'b0, 1'b0, 0, 0, 0);        // illegal
        run_instr(6'b000010, 6'b0, 1'b0, 2, 0, 0);        // j
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, 0);   // unknown funct -> add

        for (int k = 0; k < 250; k++) begin
            op = ops[$urandom_range(0, 10)];
            if (op == 6'b111111) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
            cut = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), cut);
            if (cut > 0) do_reset($urandom_range(1, 3));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
